// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (restoring) unit for the execute stage.
// Define MULTDIV_DIV_EN to build the divider; otherwise ctrl_DIV answers as a divide-by-zero.
module multdiv (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);

`ifdef MULTDIV_DIV_EN
   typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, FIXUP, DONE} stateT;
`else
   typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} stateT;
`endif

   stateT              state;
   stateT              stateNext;
   logic [4:0]         count;
   logic signed [31:0] mcand;
   logic [64:0]        prodReg;
   logic               opIsDiv;
   logic signed [33:0] hiExt;
   logic signed [33:0] boothSum;

`ifdef MULTDIV_DIV_EN
   logic [31:0]        quo;
   logic [31:0]        rem;
   logic [31:0]        dmag;
   logic               negQ;
   logic               divExc;
   logic               divZero;
   logic [32:0]        divShift;
   logic [33:0]        divDiff;
`endif

   // Booth digit selection: window {b[i+1], b[i], b[i-1]} picks 0, +-M or +-2M.
   function automatic logic signed [33:0] boothAddend(input logic [2:0] window,
                                                      input logic signed [31:0] m);
      logic signed [33:0] m1;
      logic signed [33:0] m2;
      m1 = {{2{m[31]}}, m};
      m2 = {m[31], m, 1'b0};
      case (window)
         3'b001, 3'b010: boothAddend = m1;
         3'b011:         boothAddend = m2;
         3'b100:         boothAddend = -m2;
         3'b101, 3'b110: boothAddend = -m1;
         default:        boothAddend = '0;
      endcase
   endfunction

   // Signed 32-bit overflow: bits 63..31 of the product must all match.
   function automatic logic mulOverflow(input logic [32:0] top);
      mulOverflow = !((top == '0) || (top == '1));
   endfunction

   function automatic logic [31:0] magnitude(input logic signed [31:0] v);
      magnitude = v[31] ? -v : v;
   endfunction

   always_comb begin
      hiExt    = {{2{prodReg[64]}}, prodReg[64:33]};
      boothSum = hiExt + boothAddend(prodReg[2:0], mcand);
   end

`ifdef MULTDIV_DIV_EN
   always_comb begin
      divZero  = (data_operandB == 32'd0);
      divShift = {rem, quo[31]};
      divDiff  = {1'b0, divShift} - {2'b00, dmag};
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // A start strobe overrides whatever is in flight; ctrl_MULT wins over ctrl_DIV.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    stateNext = IDLE;
         MUL_RUN: if (count == 5'd15) stateNext = DONE;
`ifdef MULTDIV_DIV_EN
         DIV_RUN: if (count == 5'd31) stateNext = FIXUP;
         FIXUP:   stateNext = DONE;
`endif
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      if (ctrl_MULT) begin
         stateNext = MUL_RUN;
      end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
         stateNext = divZero ? DONE : DIV_RUN;
`else
         stateNext = DONE;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count          <= '0;
         mcand          <= '0;
         prodReg        <= '0;
         opIsDiv        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
`ifdef MULTDIV_DIV_EN
         quo            <= '0;
         rem            <= '0;
         dmag           <= '0;
         negQ           <= 1'b0;
         divExc         <= 1'b0;
`endif
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_MULT) begin
            count   <= '0;
            opIsDiv <= 1'b0;
            mcand   <= data_operandA;
            prodReg <= {32'd0, data_operandB, 1'b0};
         end else if (ctrl_DIV) begin
            count   <= '0;
            opIsDiv <= 1'b1;
`ifdef MULTDIV_DIV_EN
            quo     <= divZero ? 32'd0 : magnitude(data_operandA);
            rem     <= '0;
            dmag    <= magnitude(data_operandB);
            negQ    <= data_operandA[31] ^ data_operandB[31];
            divExc  <= divZero ||
                       (data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF);
`endif
         end else begin
            case (state)
               MUL_RUN: begin
                  prodReg <= {boothSum, prodReg[32:2]};
                  count   <= count + 5'd1;
               end
`ifdef MULTDIV_DIV_EN
               DIV_RUN: begin
                  // Restoring step: keep the trial difference only if it did not borrow.
                  if (!divDiff[33]) begin
                     rem <= divDiff[31:0];
                     quo <= {quo[30:0], 1'b1};
                  end else begin
                     rem <= divShift[31:0];
                     quo <= {quo[30:0], 1'b0};
                  end
                  count <= count + 5'd1;
               end
               FIXUP: begin
                  if (negQ) quo <= -quo;
               end
`endif
               DONE: begin
                  data_resultRDY <= 1'b1;
`ifdef MULTDIV_DIV_EN
                  data_result    <= opIsDiv ? quo : prodReg[32:1];
                  data_exception <= opIsDiv ? divExc : mulOverflow(prodReg[64:32]);
`else
                  data_result    <= opIsDiv ? 32'd0 : prodReg[32:1];
                  data_exception <= opIsDiv ? 1'b1 : mulOverflow(prodReg[64:32]);
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: stimulus pushes expected responses, a negedge monitor pops on RDY.
// Follows MULTDIV_DIV_EN the same way the design does.
module tb_multdiv;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   multdiv dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          due;
      string       tag;
   } expT;

   expT sbq[$];
   int  nChecks = 0;
   int  nFails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // Reference behaviour straight from the arithmetic rules, plus response latency in edges.
   function automatic void model(input logic isMul, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e, output int lat);
      longint p;
      int     sa;
      int     sb;
      sa = a;
      sb = b;
      if (isMul) begin
         p   = longint'(sa) * longint'(sb);
         r   = p[31:0];
         e   = (p > 64'sd2147483647) || (p < -64'sd2147483648);
         lat = 17;
      end else begin
`ifdef MULTDIV_DIV_EN
         if (sb == 0) begin
            r = 32'd0; e = 1'b1; lat = 1;
         end else if (a == 32'h8000_0000 && sb == -1) begin
            r = 32'h8000_0000; e = 1'b1; lat = 34;
         end else begin
            r = sa / sb; e = 1'b0; lat = 34;
         end
`else
         r = 32'd0; e = 1'b1; lat = 1;
`endif
      end
   endfunction

   // Anything not yet presenting RDY is abandoned by a restart or reset.
   function automatic void dropInFlight();
      expT keep[$];
      foreach (sbq[i]) if (sbq[i].due <= cyc) keep.push_back(sbq[i]);
      sbq = keep;
   endfunction

   // Called at posedge+2; the strobe is sampled by the next edge (edge S).
   task automatic issue(input logic isMul, input logic both, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
      expT         ent;
      logic [31:0] r;
      logic        e;
      int          lat;
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = isMul | both;
      ctrl_DIV      = ~isMul | both;
      dropInFlight();
      model(isMul | both, a, b, r, e, lat);
      ent.res = r;
      ent.exc = e;
      ent.due = cyc + 1 + lat;
      ent.tag = tag;
      sbq.push_back(ent);
      @(posedge clock); #2;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom();
      data_operandB = $urandom();
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (sbq.size() != 0 && n < budget) begin
         @(posedge clock); #2;
         n++;
      end
      if (sbq.size() != 0) begin
         nChecks++;
         nFails++;
         $display("FAIL drainTimeout: %0d responses outstanding after %0d cycles, required 0",
                  sbq.size(), budget);
         sbq.delete();
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock); #2;
      end
   endtask

   task automatic checkCleared(input string tag);
      check({tag, " result"}, data_result, 32'd0);
      check({tag, " exception"}, {31'd0, data_exception}, 32'd0);
      check({tag, " rdy"}, {31'd0, data_resultRDY}, 32'd0);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(15));
         4:       return -32'($urandom_range(15));
         default: return $urandom();
      endcase
   endfunction

   always @(negedge clock) begin
      if (data_resultRDY === 1'b1) begin
         if (sbq.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL unexpectedRdy: RDY high in cycle %0d, required no RDY", cyc);
         end else begin
            expT e;
            e = sbq.pop_front();
            check({e.tag, " result"}, data_result, e.res);
            check({e.tag, " exception"}, {31'd0, data_exception}, {31'd0, e.exc});
            check({e.tag, " rdyCycle"}, 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      logic isMul;
      idle(3);
      checkCleared("reset");
      reset = 1'b0;
      idle(2);

      issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, "mul7xm6");            waitDrain(40);
      issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, "mulOvf");     waitDrain(40);
      issue(1'b1, 1'b0, 32'h8000_0000, 32'd1, "mulMinx1");           waitDrain(40);
      issue(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, "divm7by2");           waitDrain(60);
      issue(1'b0, 1'b0, 32'd100, 32'hFFFF_FFF6, "div100bym10");      waitDrain(60);
      issue(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divMinByM1"); waitDrain(60);
      issue(1'b0, 1'b0, 32'd5, 32'd0, "div5by0");                    waitDrain(60);
      issue(1'b0, 1'b0, 32'd9, 32'd3, "div9by3");                    waitDrain(60);

      // Restart: divide strobed on edge S+8 of a multiply.
      issue(1'b1, 1'b0, 32'd3, 32'd4, "mulAborted");
      idle(7);
      issue(1'b0, 1'b0, 32'd20, 32'd3, "divRestart");
      waitDrain(60);

      issue(1'b1, 1'b1, 32'd6, 32'd3, "bothStrobes");                waitDrain(40);

      // Reset on edge S+10 of a divide.
      issue(1'b0, 1'b0, 32'd1000, 32'd7, "divReset");
      idle(9);
      reset = 1'b1;
      dropInFlight();
      idle(1);
      reset = 1'b0;
      checkCleared("midReset");
      idle(40);

      // Back-to-back: second multiply strobed during the RDY cycle.
      issue(1'b1, 1'b0, 32'd12345, 32'hFFFF_0001, "b2bFirst");
      idle(17);
      check("b2b rdyBeforeStrobe", {31'd0, data_resultRDY}, 32'd1);
      issue(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, "b2bSecond");
      waitDrain(40);

      // Reset dominates a simultaneous start strobe.
      issue(1'b1, 1'b0, 32'd9, 32'd9, "preResetMul");
      waitDrain(40);
      reset         = 1'b1;
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd5;
      data_operandB = 32'd5;
      dropInFlight();
      idle(1);
      reset     = 1'b0;
      ctrl_MULT = 1'b0;
      checkCleared("resetVsStrobe");
      idle(25);

      for (int i = 0; i < 40; i++) begin
         isMul = 1'($urandom_range(1));
         issue(isMul, 1'b0, pickOperand(), pickOperand(), isMul ? "randMul" : "randDiv");
         if ($urandom_range(4) == 0) idle($urandom_range(20));
         else waitDrain(60);
      end
      waitDrain(60);
      idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
